stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N-input stream multiplexer with valid/ready handshakes and a registered output stage.
- Successor to the combinational 4:1 select mux.
- Adds run-time selectable arbitration: external select or round-robin.
- Sits between multiple producer channels and a single consumer, e.g. merging sensor or UART byte streams onto one bus.

Parameters:
N, 4, number of input channels (2..16)
WIDTH, 8, data bits per channel
SELW, derived = max(1, clog2(N)), select and channel-index width (localparam, not overridable)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = external select, 1 = round-robin
sel  input  SELW  channel index used when mode=0
in_valid  input  N  per-channel valid
in_ready  output  N  per-channel ready (combinational)
in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
out_valid  output  1  output register holds a beat
out_ready  input  1  consumer accepts beat
out_data  output  WIDTH  registered data
out_ch  output  SELW  index of the channel that sourced out_data

Behaviour:
- One clock domain (clk); reset is asynchronous, active-low (rst_n).
- Reset values: out_valid=0, out_data=0, out_ch=0, rr pointer=0, lock state cleared.
- While rst_n=0, in_ready=0.
- load = !out_valid || out_ready. This is a one-entry pipeline: back-to-back beats at full rate when out_ready=1.
- Grant is computed only when load=1. At most one grant bit per cycle.
- mode=0: grant channel sel if in_valid[sel]=1. No grant if sel>=N or in_valid[sel]=0.
- mode=1: search from pointer ptr upward with wrap (ptr, ptr+1, ..., N-1, 0, ..., ptr-1). The first channel with in_valid=1 is granted.
- in_ready[i] = load && grant[i]. A transfer on channel i occurs when in_valid[i] && in_ready[i].
- On a transfer from channel g at a rising edge:
  - out_data <= in_data[g]
  - out_ch <= g
  - out_valid <= 1
  - if mode=1, ptr <= (g+1) mod N
- Load with no grant: out_valid <= 0; out_data and out_ch hold their values.
- out_valid=1 && out_ready=0: out_data and out_ch hold; all in_ready=0.
- Latency: one cycle from input transfer to out_valid.
- ptr advances only on round-robin grants. It is unchanged in mode=0 and is not cleared on a mode change. A mode change applies to the next arbitration.
- Wrap-around: with g=N-1, ptr becomes 0.
- Starvation bound in mode=1: with all channels valid, each channel is granted once every N transfers.
- Reset asserted mid-transfer: the beat in the output register is discarded and out_valid drops immediately (asynchronous). Producers must re-present data; no beat is duplicated after reset.
- in_data of non-granted channels is ignored. X on a non-granted lane must not propagate to out_data.

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN.
- Defined:
  - Adds ports in_last (input, N) and out_last (output, 1; reset 0, registered alongside out_data).
  - When a beat with in_last=0 transfers from channel g, the arbiter locks to g. Only g may be granted, regardless of mode and sel, until a beat with in_last=1 from g transfers. Lock then releases.
  - ptr is updated only on the beat with last=1.
  - Reset clears the lock.
- Not defined: no in_last/out_last ports; every beat is arbitrated independently.

Test Plan:
- Reset: assert rst_n=0 with all in_valid=1. Required: out_valid=0, in_ready=0, out_data=0. Release rst_n; first beat appears one cycle after the first transfer.
- mode=0, N=4, sel=2, in_valid=4'b1111, in_data lanes 0x11/0x22/0x33/0x44, out_ready=1. Required: out_data=0x33, out_ch=2 every cycle; in_ready=4'b0100. Set sel=2 with in_valid[2]=0: no grant, out_valid drops to 0.
- mode=1, all valid, out_ready=1 for 8 cycles. Required: out_ch sequence 0,1,2,3,0,1,2,3, including the wrap from 3 to 0. Then in_valid=4'b1010: required 1,3,1,3.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1. Required: out_data/out_ch stable, in_ready=0. On release, no beat is lost or duplicated (scoreboard per channel).
- Reset mid-stream in mode=1 after granting channel 2. Required: out_valid=0 immediately; after release, first round-robin grant starts from channel 0.
- With STREAM_MUX_PKT_LOCK_EN defined: channel 1 sends a 3-beat packet (last on beat 3) while channels 0 and 2 are valid. Required: out_ch=1,1,1 with out_last=0,0,1, then channel 2 is granted next.

Source files
------------

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-input valid/ready stream multiplexer with selectable arbitration
//
// Merges N producer streams onto one consumer through a one-entry registered
// output stage. Arbitration is external select (mode=0) or round-robin (mode=1).
// Optional packet lock is enabled by defining STREAM_MUX_PKT_LOCK_EN.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   mode       0 = external select, 1 = round-robin
//   sel        channel index used when mode=0
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational)
//   in_data    channel i occupies bits [i*WIDTH +: WIDTH]
//   in_last    per-channel end-of-packet (STREAM_MUX_PKT_LOCK_EN only)
//   out_valid  output register holds a beat
//   out_ready  consumer accepts beat
//   out_data   registered data
//   out_ch     index of the channel that sourced out_data
//   out_last   registered end-of-packet (STREAM_MUX_PKT_LOCK_EN only)

module stream_mux_rr #(
   parameter int  N     = 4,
   parameter int  WIDTH = 8,
   localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mode,
   input  logic [SELW-1:0]    sel,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [N*WIDTH-1:0] in_data,
`ifdef STREAM_MUX_PKT_LOCK_EN
   input  logic [N-1:0]       in_last,
   output logic               out_last,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_ch
);

   logic [SELW-1:0]  ptr;
   logic [SELW-1:0]  ptr_next;
   logic             load;
   logic             grant_any;
   logic [SELW-1:0]  grant_idx;
   logic [N-1:0]     grant;
   logic [WIDTH-1:0] sel_data;

   // lock_hold forces the grant onto lock_ch; ptr_step says whether this
   // transfer may advance the round-robin pointer.
   logic             lock_hold;
   logic [SELW-1:0]  lock_ch;
   logic             ptr_step;

   // The output register can accept a new beat when empty or being drained.
   assign load = !out_valid || out_ready;

   always_comb begin : arbitrate
      int              idx;
      logic [SELW-1:0] cand;
      grant_any = 1'b0;
      grant_idx = '0;
      idx       = 0;
      cand      = '0;
      if (lock_hold) begin
         if (in_valid[lock_ch]) begin
            grant_any = 1'b1;
            grant_idx = lock_ch;
         end
      end else if (!mode) begin
         if (int'(sel) < N) begin
            if (in_valid[sel]) begin
               grant_any = 1'b1;
               grant_idx = sel;
            end
         end
      end else begin
         // Search ptr, ptr+1, ... with wrap; first valid channel wins.
         for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
               idx = idx - N;
            end
            cand = SELW'(idx);
            if (!grant_any && in_valid[cand]) begin
               grant_any = 1'b1;
               grant_idx = cand;
            end
         end
      end
   end

   always_comb begin
      grant = '0;
      if (grant_any) begin
         grant[grant_idx] = 1'b1;
      end
   end

   assign in_ready = (rst_n && load) ? grant : '0;

   // Equality-selected mux: only the granted lane reaches sel_data, so X on
   // an idle lane cannot leak into the output register.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_idx == SELW'(i)) begin
            sel_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign ptr_next = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= '0;
      end else if (load) begin
         if (grant_any) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= grant_idx;
            if (mode && ptr_step) begin
               ptr <= ptr_next;
            end
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef STREAM_MUX_PKT_LOCK_EN
   logic lock_active;
   logic [SELW-1:0] lock_ch_q;

   assign lock_hold = lock_active;
   assign lock_ch   = lock_ch_q;
   // Pointer moves only when a packet completes.
   assign ptr_step  = in_last[grant_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_active <= 1'b0;
         lock_ch_q   <= '0;
         out_last    <= 1'b0;
      end else if (load && grant_any) begin
         out_last    <= in_last[grant_idx];
         lock_active <= !in_last[grant_idx];
         lock_ch_q   <= grant_idx;
      end
   end
`else
   assign lock_hold = 1'b0;
   assign lock_ch   = '0;
   assign ptr_step  = 1'b1;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - scoreboard testbench for stream_mux_rr

module tb_stream_mux_rr;

   localparam int N     = 4;
   localparam int WIDTH = 8;
   localparam int SELW  = 2;

   logic               clk;
   logic               rst_n;
   logic               mode;
   logic [SELW-1:0]    sel;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_last;
   logic               out_last;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic [SELW-1:0]    out_ch;

   typedef struct packed {
      logic [SELW-1:0]  ch;
      logic [WIDTH-1:0] data;
      logic             last;
   } beat_t;

   beat_t sb_q[$];
   beat_t mon_exp;
   int    n_tests = 0;
   int    n_fail  = 0;

   stream_mux_rr #(.N(N), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
`ifdef STREAM_MUX_PKT_LOCK_EN
      .in_last   (in_last),
      .out_last  (out_last),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ch    (out_ch)
   );

`ifndef STREAM_MUX_PKT_LOCK_EN
   assign out_last = 1'b0;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running, need done");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, need %0h", name, act, exp);
      end
   endtask

   task automatic push(input int ch, input logic [WIDTH-1:0] data, input logic last);
      beat_t b;
      b.ch   = SELW'(ch);
      b.data = data;
      b.last = last;
      sb_q.push_back(b);
   endtask

   task automatic set_lanes(input logic [WIDTH-1:0] base);
      for (int i = 0; i < N; i++) begin
         in_data[i*WIDTH +: WIDTH] = base + WIDTH'(i);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: a beat is consumed at the next rising edge when valid && ready.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_beat: got ch %0d data %0h, need no beat", out_ch, out_data);
            end else begin
               mon_exp = sb_q.pop_front();
               check("mon_ch", 32'(out_ch), 32'(mon_exp.ch));
               check("mon_data", 32'(out_data), 32'(mon_exp.data));
`ifdef STREAM_MUX_PKT_LOCK_EN
               check("mon_last", 32'(out_last), 32'(mon_exp.last));
`endif
            end
         end
      end
   end

   int rr_all [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   int rr_odd [4] = '{1, 3, 1, 3};

   initial begin
      rst_n     = 1'b1;
      mode      = 1'b0;
      sel       = 2'd2;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      in_last   = '0;
      in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
      #1;
      rst_n = 1'b0;
      repeat (3) step();
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_out_ch", 32'(out_ch), 0);

      // External select, channel 2 every cycle.
      rst_n = 1'b1;
      #1;
      check("first_latency", 32'(out_valid), 0);
      for (int i = 0; i < 4; i++) begin
         check("m0_in_ready", 32'(in_ready), 32'h4);
         push(2, 8'h33, 1'b0);
         step();
         check("m0_out_valid", 32'(out_valid), 1);
      end
      in_valid = 4'b1011;
      #1;
      check("m0_nogrant_ready", 32'(in_ready), 0);
      step();
      check("m0_nogrant_valid", 32'(out_valid), 0);

      // Round-robin, all channels valid, then only 1 and 3.
      mode     = 1'b1;
      in_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         set_lanes(8'h40 + 8'(i * 8));
         #1;
         check("rr_all_ready", 32'(in_ready), 32'(1) << rr_all[i]);
         push(rr_all[i], 8'h40 + 8'(i * 8) + 8'(rr_all[i]), 1'b0);
         step();
      end
      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         set_lanes(8'h80 + 8'(i * 8));
         #1;
         check("rr_odd_ready", 32'(in_ready), 32'(1) << rr_odd[i]);
         push(rr_odd[i], 8'h80 + 8'(i * 8) + 8'(rr_odd[i]), 1'b0);
         step();
      end

      // Backpressure while holding channel 0.
      in_valid = 4'b1111;
      set_lanes(8'hA0);
      #1;
      check("bp_pre_ready", 32'(in_ready), 32'h1);
      push(0, 8'hA0, 1'b0);
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_lanes(8'hB0 + 8'(i * 4));
         #1;
         check("bp_in_ready", 32'(in_ready), 0);
         check("bp_out_valid", 32'(out_valid), 1);
         check("bp_out_data", 32'(out_data), 32'hA0);
         check("bp_out_ch", 32'(out_ch), 0);
         step();
      end
      out_ready = 1'b1;
      set_lanes(8'hC0);
      #1;
      check("bp_rel_ready", 32'(in_ready), 32'h2);
      push(1, 8'hC1, 1'b0);
      step();
      set_lanes(8'hD0);
      #1;
      check("bp_next_ready", 32'(in_ready), 32'h4);
      push(2, 8'hD2, 1'b0);
      step();

      // Reset while channel 2's beat sits in the output register.
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_ready", 32'(in_ready), 0);
      check("mid_rst_pending", 32'(sb_q.size()), 1);
      sb_q.delete();
      repeat (2) step();
      rst_n = 1'b1;
      set_lanes(8'hE0);
      #1;
      check("post_rst_ready", 32'(in_ready), 32'h1);
      push(0, 8'hE0, 1'b0);
      step();
      set_lanes(8'hF0);
      #1;
      check("post_rst_ready2", 32'(in_ready), 32'h2);
      push(1, 8'hF1, 1'b0);
      step();

`ifdef STREAM_MUX_PKT_LOCK_EN
      // Channel 1 packet of three beats while 0 and 2 are also valid.
      mode     = 1'b0;
      sel      = 2'd1;
      in_valid = 4'b0111;
      in_last  = 4'b0000;
      set_lanes(8'h10);
      #1;
      check("lock_b1_ready", 32'(in_ready), 32'h2);
      push(1, 8'h11, 1'b0);
      step();
      mode = 1'b1;
      sel  = 2'd0;
      set_lanes(8'h20);
      #1;
      check("lock_b2_ready", 32'(in_ready), 32'h2);
      push(1, 8'h21, 1'b0);
      step();
      in_last = 4'b0010;
      set_lanes(8'h30);
      #1;
      check("lock_b3_ready", 32'(in_ready), 32'h2);
      push(1, 8'h31, 1'b1);
      step();
      in_last = 4'b0000;
      set_lanes(8'h50);
      #1;
      check("lock_after_ready", 32'(in_ready), 32'h4);
      push(2, 8'h52, 1'b0);
      step();
`endif

      in_valid = '0;
      #1;
      step();
      step();
      check("drain_empty", 32'(sb_q.size()), 0);
      check("drain_valid", 32'(out_valid), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
